// File: rtl/sel_mux_rr.sv
// N-channel registered selector with valid/ready flow control.
// Supports direct channel select and round-robin arbitration over valid channels.
module sel_mux_rr #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SEL_W:0]   CHAN_CNT  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0] ch_data [CHANNELS];

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_d;
  logic [SEL_W:0]   scan_idx;
  logic             rr_hit;
  logic [SEL_W-1:0] rr_grant;
  logic             grant_ok;
  logic [SEL_W-1:0] grant;
  logic             can_load;
  logic             xfer;

  logic [WIDTH-1:0] out_data_d;
  logic [SEL_W-1:0] out_chan_d;
  logic             out_valid_d;

  // Unpack the flat input bus into per-channel words.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
  end

  // Round-robin scan starting at ptr; index wraps at CHANNELS, not 2^SEL_W.
  always_comb begin
    rr_hit   = 1'b0;
    rr_grant = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      scan_idx = {1'b0, ptr} + (SEL_W+1)'(i);
      if (scan_idx >= CHAN_CNT) begin
        scan_idx = scan_idx - CHAN_CNT;
      end
      if (!rr_hit && in_valid[scan_idx[SEL_W-1:0]]) begin
        rr_hit   = 1'b1;
        rr_grant = scan_idx[SEL_W-1:0];
      end
    end
  end

  // Grant selection; out-of-range direct selects never grant.
  always_comb begin
    grant_ok = 1'b0;
    grant    = '0;
    if (mode) begin
      grant_ok = rr_hit;
      grant    = rr_grant;
    end else if (({1'b0, sel} < CHAN_CNT) && in_valid[sel]) begin
      grant_ok = 1'b1;
      grant    = sel;
    end
  end

  assign can_load = !out_valid || out_ready;
  assign xfer     = grant_ok && can_load && !reset;
  assign in_ready = xfer ? (CHANNELS'(1) << grant) : '0;

  // Next-state for the output stage and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data;
    out_chan_d  = out_chan;
    out_valid_d = out_valid;
    ptr_d       = ptr;
    if (xfer) begin
      out_data_d  = ch_data[grant];
      out_chan_d  = grant;
      out_valid_d = 1'b1;
      if (mode) begin
        ptr_d = (grant == LAST_CHAN) ? '0 : grant + SEL_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      out_data  <= out_data_d;
      out_chan  <= out_chan_d;
      out_valid <= out_valid_d;
      ptr       <= ptr_d;
    end
  end

endmodule

// File: tb/tb_sel_mux_rr.sv
// Directed bench for sel_mux_rr: an 8-channel instance and a 6-channel instance
// exercising direct select, round-robin, backpressure, drain, reset and wrap.
module tb_sel_mux_rr;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // 8-channel, 32-bit instance
  logic         a_reset, a_mode, a_out_ready, a_out_valid;
  logic [2:0]   a_sel, a_out_chan;
  logic [255:0] a_in_data;
  logic [7:0]   a_in_valid, a_in_ready;
  logic [31:0]  a_out_data;

  // 6-channel, 8-bit instance
  logic         b_reset, b_mode, b_out_ready, b_out_valid;
  logic [2:0]   b_sel, b_out_chan;
  logic [47:0]  b_in_data;
  logic [5:0]   b_in_valid, b_in_ready;
  logic [7:0]   b_out_data;

  sel_mux_rr #(.WIDTH(32), .CHANNELS(8), .SEL_W(3)) dut_a (
    .clock(clock), .reset(a_reset), .mode(a_mode), .sel(a_sel),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_chan(a_out_chan), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
  );

  sel_mux_rr #(.WIDTH(8), .CHANNELS(6), .SEL_W(3)) dut_b (
    .clock(clock), .reset(b_reset), .mode(b_mode), .sel(b_sel),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_chan(b_out_chan), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int rr_exp [8] = '{1, 2, 4, 7, 1, 2, 4, 7};
  int b_exp  [4] = '{0, 5, 0, 5};

  initial begin
    a_reset = 1'b1; a_mode = 1'b0; a_sel = 3'd0; a_in_valid = 8'hFF; a_out_ready = 1'b1;
    b_reset = 1'b1; b_mode = 1'b0; b_sel = 3'd0; b_in_valid = 6'h00; b_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) a_in_data[k*32 +: 32] = 32'(k + 'h10);
    for (int k = 0; k < 6; k++) b_in_data[k*8 +: 8] = 8'(k + 'h20);
    tick();
    tick();

    // Reset state; in_ready forced low even with a valid grant available
    check("rst_valid", 64'(a_out_valid), 64'd0);
    check("rst_data",  64'(a_out_data),  64'd0);
    check("rst_chan",  64'(a_out_chan),  64'd0);
    check("rst_ready", 64'(a_in_ready),  64'd0);

    // Direct select of channel 5
    a_reset = 1'b0; a_sel = 3'd5;
    #1;
    check("dir_ready0", 64'(a_in_ready), 64'h20);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dir_data",  64'(a_out_data),  64'h15);
      check("dir_chan",  64'(a_out_chan),  64'd5);
      check("dir_valid", 64'(a_out_valid), 64'd1);
      check("dir_ready", 64'(a_in_ready),  64'h20);
    end

    // Round-robin over 0b1001_0110; pointer still 0 after direct mode
    a_mode = 1'b1; a_in_valid = 8'h96;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rr_ready", 64'(a_in_ready), 64'(1) << rr_exp[i]);
      tick();
      check("rr_chan", 64'(a_out_chan), 64'(rr_exp[i]));
      check("rr_data", 64'(a_out_data), 64'(rr_exp[i] + 'h10));
    end

    // Backpressure holds channel 7's item
    a_out_ready = 1'b0;
    #1;
    check("bp_ready0", 64'(a_in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", 64'(a_out_valid), 64'd1);
      check("bp_chan",  64'(a_out_chan),  64'd7);
      check("bp_data",  64'(a_out_data),  64'h17);
      check("bp_ready", 64'(a_in_ready),  64'd0);
    end
    a_out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(a_in_ready), 64'h02);
    tick();
    check("bp_next_chan",  64'(a_out_chan),  64'd1);
    check("bp_next_data",  64'(a_out_data),  64'h11);
    check("bp_next_valid", 64'(a_out_valid), 64'd1);

    // Drain to empty
    a_in_valid = 8'h00;
    #1;
    check("drain_ready", 64'(a_in_ready), 64'd0);
    tick();
    check("drain_valid", 64'(a_out_valid), 64'd0);
    check("drain_data",  64'(a_out_data),  64'h11);
    check("drain_chan",  64'(a_out_chan),  64'd1);
    tick();
    check("drain_valid2", 64'(a_out_valid), 64'd0);

    // Load channel 2 so ptr becomes 3, then reset with item held
    a_in_valid = 8'h04;
    #1;
    check("pre_rst_ready", 64'(a_in_ready), 64'h04);
    tick();
    check("pre_rst_chan", 64'(a_out_chan), 64'd2);
    a_in_valid = 8'hFF; a_reset = 1'b1;
    #1;
    check("mid_rst_ready", 64'(a_in_ready), 64'd0);
    tick();
    check("mid_rst_valid", 64'(a_out_valid), 64'd0);
    check("mid_rst_data",  64'(a_out_data),  64'd0);
    check("mid_rst_chan",  64'(a_out_chan),  64'd0);
    a_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("post_rst_ready", 64'(a_in_ready), 64'(1) << i);
      tick();
      check("post_rst_chan", 64'(a_out_chan), 64'(i));
    end

    // Mode change takes effect on the same cycle's grant
    a_mode = 1'b0; a_sel = 3'd6;
    #1;
    check("mode_sw_ready", 64'(a_in_ready), 64'h40);
    check("mode_sw_hold",  64'(a_out_chan), 64'd3);
    tick();
    check("mode_sw_chan", 64'(a_out_chan), 64'd6);
    check("mode_sw_data", 64'(a_out_data), 64'h16);

    // Six channels: out-of-range selects never grant
    b_reset = 1'b0; b_mode = 1'b0; b_sel = 3'd7; b_in_valid = 6'h3F;
    #1;
    check("b_sel7_ready", 64'(b_in_ready), 64'd0);
    tick();
    check("b_sel7_valid", 64'(b_out_valid), 64'd0);
    b_sel = 3'd6;
    #1;
    check("b_sel6_ready", 64'(b_in_ready), 64'd0);
    tick();
    check("b_sel6_valid", 64'(b_out_valid), 64'd0);
    b_sel = 3'd5;
    #1;
    check("b_sel5_ready", 64'(b_in_ready), 64'h20);
    tick();
    check("b_sel5_chan", 64'(b_out_chan), 64'd5);
    check("b_sel5_data", 64'(b_out_data), 64'h25);

    // Round-robin wraps at 6
    b_mode = 1'b1; b_in_valid = 6'b100001;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("b_rr_ready", 64'(b_in_ready), 64'(1) << b_exp[i]);
      tick();
      check("b_rr_chan", 64'(b_out_chan), 64'(b_exp[i]));
      check("b_rr_data", 64'(b_out_data), 64'(b_exp[i] + 'h20));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
